fetch_seq_ctrl: RTL and testbench

Sequences the instruction-fetch stage: decides each cycle whether the PC register advances and which next-PC source it selects.
- Handshakes with instruction memory (req/ack).
- Merges redirect requests from decode and exception logic by fixed priority.
- Buffers a redirect that arrives while a fetch is outstanding.
- Drives the PC enable, the 3-bit next-PC select and the exception-branch condition of the fetch unit.

---
 rtl/fetch_seq_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_seq_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: PC advance, next-PC source arbitration, one-entry redirect buffer, imem timeout.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_i,
  input  logic       br_req,
  input  logic       j_req,
  input  logic       jr_req,
  input  logic       ex_req,
  input  logic       imem_ack,
  output logic       imem_req,
  output logic       pc_en,
  output logic [2:0] pc_src,
  output logic       br_cond,
  output logic       instr_valid,
  output logic       pend_valid,
  output logic       fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redir_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  // Source codes are numbered in priority order, so a larger code always wins.
  localparam logic [2:0] SRC_SEQ = 3'b000;
  localparam logic [2:0] SRC_BR  = 3'b001;
  localparam logic [2:0] SRC_J   = 3'b010;
  localparam logic [2:0] SRC_JR  = 3'b011;
  localparam logic [2:0] SRC_EX  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [2:0]       pend_src;
  logic [CNT_W-1:0] to_cnt;
  logic [2:0]       live_src;
  logic             live_any;
  logic [2:0]       sel_src;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    live_src = SRC_SEQ;
    if (br_req) live_src = SRC_BR;
    if (j_req)  live_src = SRC_J;
    if (jr_req) live_src = SRC_JR;
    if (ex_req) live_src = SRC_EX;
    live_any = br_req | j_req | jr_req | ex_req;

    if (live_any)        sel_src = live_src;
    else if (pend_valid) sel_src = pend_src;
    else                 sel_src = SRC_SEQ;
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == FETCH) && imem_ack;
    pc_en       = ((state == FETCH) && imem_ack && !stall_i) ||
                  ((state == HOLD) && !stall_i);
    pc_src      = pc_en ? sel_src : SRC_SEQ;
    br_cond     = pc_en && (sel_src == SRC_EX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pend_valid <= 1'b0;
      pend_src   <= SRC_SEQ;
      to_cnt     <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (imem_ack && stall_i) state <= HOLD;
        HOLD:    if (!stall_i) state <= FETCH;
        default: state <= BOOT;
      endcase

      // Any PC load consumes the entry: either it is the winner or a live request outranks it.
      if (pc_en) begin
        pend_valid <= 1'b0;
        pend_src   <= SRC_SEQ;
      end else if (live_any && (!pend_valid || (live_src > pend_src))) begin
        pend_valid <= 1'b1;
        pend_src   <= live_src;
      end

      if ((state == FETCH) && !imem_ack) begin
        if (to_cnt != CNT_LAST) to_cnt <= to_cnt + 1'b1;
        else                    fetch_err <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_redir_cnt <= '0;
    end else begin
      if ((state == HOLD) || ((state == FETCH) && !imem_ack))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_en && (pc_src != SRC_SEQ))
        perf_redir_cnt <= perf_redir_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: per-cycle expected outputs are queued with the stimulus
// and popped for comparison mid-cycle, once the combinational outputs have settled.
module tb_fetch_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_i, br_req, j_req, jr_req, ex_req, imem_ack;
  logic       imem_req, pc_en, br_cond, instr_valid, pend_valid, fetch_err;
  logic [2:0] pc_src;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_redir_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       imem_req;
    logic       pc_en;
    logic [2:0] pc_src;
    logic       br_cond;
    logic       instr_valid;
    logic       pend_valid;
    logic       fetch_err;
  } exp_t;

  exp_t sb[$];

  fetch_seq_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_req      (br_req),
    .j_req       (j_req),
    .jr_req      (jr_req),
    .ex_req      (ex_req),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .br_cond     (br_cond),
    .instr_valid (instr_valid),
    .pend_valid  (pend_valid),
    .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_redir_cnt (perf_redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t xp(logic ir, logic pe, logic [2:0] ps, logic bc,
                              logic iv, logic pv, logic fe);
    exp_t e;
    e.imem_req    = ir;
    e.pc_en       = pe;
    e.pc_src      = ps;
    e.br_cond     = bc;
    e.instr_valid = iv;
    e.pend_valid  = pv;
    e.fetch_err   = fe;
    return e;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, compare at the falling edge, return at the next posedge+1.
  task automatic step(input string name, input logic st, input logic b, input logic j,
                      input logic jr, input logic ex, input logic ak, input exp_t e);
    exp_t x;
    stall_i  = st;
    br_req   = b;
    j_req    = j;
    jr_req   = jr;
    ex_req   = ex;
    imem_ack = ak;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    check({name, ".imem_req"},    3'(imem_req),    3'(x.imem_req));
    check({name, ".pc_en"},       3'(pc_en),       3'(x.pc_en));
    check({name, ".pc_src"},      pc_src,          x.pc_src);
    check({name, ".br_cond"},     3'(br_cond),     3'(x.br_cond));
    check({name, ".instr_valid"}, 3'(instr_valid), 3'(x.instr_valid));
    check({name, ".pend_valid"},  3'(pend_valid),  3'(x.pend_valid));
    check({name, ".fetch_err"},   3'(fetch_err),   3'(x.fetch_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; br_req = 1'b0; j_req = 1'b0; jr_req = 1'b0; ex_req = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //            name          st br j  jr ex ack     ir pe src   bc iv pv fe
    step("reset",        0, 0, 0, 0, 0, 1, xp(0, 0, 3'd0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("boot",         0, 0, 0, 0, 0, 1, xp(0, 0, 3'd0, 0, 0, 0, 0));
    step("seq1",         0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));
    step("seq2",         0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    // Jump outranks branch; applied with the ack, nothing buffered.
    step("j_br",         0, 1, 1, 0, 0, 1, xp(1, 1, 3'd2, 0, 1, 0, 0));
    step("after_jbr",    0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    // Branch during missing ack is buffered and applied on the next ack.
    step("miss_br",      0, 1, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("miss2",        0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 1, 0));
    step("miss3",        0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 1, 0));
    step("ack_pend",     0, 0, 0, 0, 0, 1, xp(1, 1, 3'd1, 0, 1, 1, 0));
    step("after_pend",   0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    // Higher live request overwrites the entry, a lower one is ignored.
    step("ovr_br",       0, 1, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("ovr_j",        0, 0, 1, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 1, 0));
    step("ovr_lowbr",    0, 1, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 1, 0));
    step("ovr_ack",      0, 0, 0, 0, 0, 1, xp(1, 1, 3'd2, 0, 1, 1, 0));

    // Exception with ack wins over a buffered branch and discards it.
    step("ex_buf",       0, 1, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("ex_ack",       0, 0, 0, 0, 1, 1, xp(1, 1, 3'd4, 1, 1, 1, 0));
    step("ex_after",     0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    // Stall after an ack, register jump pulsed during the stall.
    step("stall_ack",    1, 0, 0, 0, 0, 1, xp(1, 0, 3'd0, 0, 1, 0, 0));
    step("hold_jr",      1, 0, 0, 1, 0, 0, xp(0, 0, 3'd0, 0, 0, 0, 0));
    step("hold2",        1, 0, 0, 0, 0, 0, xp(0, 0, 3'd0, 0, 0, 1, 0));
    step("hold3",        1, 0, 0, 0, 0, 0, xp(0, 0, 3'd0, 0, 0, 1, 0));
    step("unstall",      0, 0, 0, 0, 0, 0, xp(0, 1, 3'd3, 0, 0, 1, 0));
    step("refetch",      0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    // Stall without ack keeps fetching; stall with ack enters the hold.
    step("fstall_miss",  1, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("fstall_ack",   1, 0, 0, 0, 0, 1, xp(1, 0, 3'd0, 0, 1, 0, 0));
    step("hold_rel",     0, 0, 0, 0, 0, 0, xp(0, 1, 3'd0, 0, 0, 0, 0));

    // Timeout of 4: error visible after the 4th consecutive missing ack, then sticky.
    step("to1",          0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("to2",          0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("to3",          0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("to4",          0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 0));
    step("to5",          0, 0, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 1));
    step("to_ack",       0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 1));
    step("to_br",        0, 1, 0, 0, 0, 0, xp(1, 0, 3'd0, 0, 0, 0, 1));

    // Reset mid-fetch drops the buffered branch and the sticky error; the ack is ignored.
    rst_n = 1'b0;
    step("rst_mid",      0, 0, 0, 0, 0, 1, xp(0, 0, 3'd0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("boot2",        0, 0, 0, 0, 0, 1, xp(0, 0, 3'd0, 0, 0, 0, 0));
    step("fetch2",       0, 0, 0, 0, 0, 1, xp(1, 1, 3'd0, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
